// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: FSM state encoding, opcode/funct codes, ALU control
//               codes and the aluop type.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_if
// Description : Control bus between the multicycle controller and datapath.
//               master = controller (consumes instruction fields and flags,
//               drives selects/enables); slave = datapath.
//   op, funct         : instruction register fields
//   zero, memready    : ALU zero flag, memory access complete
//   pcen .. illegal   : datapath selects, write enables, illegal-op pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero, memready,
    output pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mc_aludec
// Description : ALU decoder. Maps aluop and the R-type funct field to the
//               3-bit ALU operation.
//   aluop_i      : 00 add, 01 sub, 10 decode funct
//   funct_i      : instr[5:0]
//   alucontrol_o : ALU operation
// Revision    : 1.0 - initial release
// ============================================================================
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUCTL_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
      ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        // Unknown functs fall back to add so the write-back still happens
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALUCTL_ADD;
          FUNCT_SUB: alucontrol_o = ALUCTL_SUB;
          FUNCT_AND: alucontrol_o = ALUCTL_AND;
          FUNCT_OR:  alucontrol_o = ALUCTL_OR;
          FUNCT_SLT: alucontrol_o = ALUCTL_SLT;
          default:   alucontrol_o = ALUCTL_ADD;
        endcase
      end
      default: alucontrol_o = ALUCTL_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Main control FSM for the multicycle MIPS datapath (shared
//               memory, single ALU). Moore outputs, except memready gating
//               irwrite/pcen in FETCH and zero gating pcen in BRANCH/BNE.
//               Stalls in FETCH, MEMRD and MEMWR until memready.
//   clk       : system clock
//   reset     : synchronous, active-high; returns to FETCH, forces all
//               write enables and illegal low while asserted
//   bus       : mc_if.master control bus
//   state_dbg : current state, zero-extended to STATE_W
// Config      : define MC_BNE_EN to decode bne (op 000101); otherwise it is
//               treated as an illegal opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  mc_if.master               bus,
  output logic [STATE_W-1:0] state_dbg
);

  state_t     state_q, state_d;
  aluop_t     w_aluop;
  logic       w_pcen, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic       w_iord, w_regdst, w_memtoreg, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    w_aluop    = ALUOP_ADD;
    w_pcen     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = bus.memready;
        w_pcen    = bus.memready;
        state_d   = bus.memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target computed here so BRANCH can take it from ALUOut
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        state_d   = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord  = 1'b1;
        state_d = bus.memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        state_d    = bus.memready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_aluop    = ALUOP_FUNCT;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_pcen    = bus.zero;
        state_d   = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_pcen    = ~bus.zero;
        state_d   = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i      (w_aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (w_alucontrol)
  );

  // Reset is synchronous, so the state is still stale during the reset
  // cycle; the enables are masked directly to keep that cycle harmless.
  assign bus.pcen       = w_pcen     & ~reset;
  assign bus.memwrite   = w_memwrite & ~reset;
  assign bus.irwrite    = w_irwrite  & ~reset;
  assign bus.regwrite   = w_regwrite & ~reset;
  assign bus.illegal    = w_illegal  & ~reset;
  assign bus.iord       = w_iord;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alucontrol = w_alucontrol;

  assign state_dbg = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller. A table of per-cycle
//               {inputs, expected state, expected outputs} records is played
//               through the controller, followed by a hand-written bne/illegal
//               sequence. Outputs packed as:
//               {pcen,memwrite,irwrite,iord, regdst,memtoreg,regwrite,alusrca,
//                alusrcb,pcsrc, alucontrol,illegal}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD = 4'd3,  ST_MEMWB = 4'd4,   ST_MEMWR = 4'd5;
  localparam logic [3:0] ST_EXE   = 4'd6,  ST_ALUWB = 4'd7,   ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;
  localparam logic [3:0] ST_BNE   = 4'd12;

  localparam logic [15:0] O_FETCH  = 16'b1010_0000_0100_0100;
  localparam logic [15:0] O_FETCHW = 16'b0000_0000_0100_0100;
  localparam logic [15:0] O_DECODE = 16'b0000_0000_1100_0100;
  localparam logic [15:0] O_ILL    = 16'b0000_0000_1100_0101;
  localparam logic [15:0] O_MEMADR = 16'b0000_0001_1000_0100;
  localparam logic [15:0] O_MEMRD  = 16'b0001_0000_0000_0100;
  localparam logic [15:0] O_MEMWB  = 16'b0000_0110_0000_0100;
  localparam logic [15:0] O_MEMWR  = 16'b0101_0000_0000_0100;
  localparam logic [15:0] O_BR_T   = 16'b1000_0001_0001_1100;
  localparam logic [15:0] O_BR_N   = 16'b0000_0001_0001_1100;
  localparam logic [15:0] O_ADDIWB = 16'b0000_0010_0000_0100;
  localparam logic [15:0] O_JUMP   = 16'b1000_0000_0010_0100;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr;
    logic [3:0] st;
    logic [15:0] out;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_dbg;
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       vecs[$];

  mc_if u_bus ();

  mc_controller #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (u_bus.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exe_out(input logic [2:0] ac);
    return {12'b0000_0001_0000, ac, 1'b0};
  endfunction

  function automatic logic [15:0] alwb_out(input logic [2:0] ac);
    return {12'b0000_1010_0000, ac, 1'b0};
  endfunction

  function automatic logic [15:0] outs();
    return {u_bus.pcen, u_bus.memwrite, u_bus.irwrite, u_bus.iord,
            u_bus.regdst, u_bus.memtoreg, u_bus.regwrite, u_bus.alusrca,
            u_bus.alusrcb, u_bus.pcsrc, u_bus.alucontrol, u_bus.illegal};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                     input logic zero, input logic mr, input logic [3:0] st,
                     input logic [15:0] out);
    vec_t v;
    v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.mr = mr;
    v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic mr);
    reset          = rst;
    u_bus.op       = op;
    u_bus.funct    = funct;
    u_bus.zero     = zero;
    u_bus.memready = mr;
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [15:0] out);
    n_checks++;
    if (state_dbg !== st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, state_dbg, st);
    end
    n_checks++;
    if (outs() !== out) begin
      n_fail++;
      $display("FAIL %s outputs: got %b expected %b", name, outs(), out);
    end
  endtask

  initial begin
    // lw, memready high: 5 cycles
    add(1, 6'h23, 6'h00, 0, 1, ST_FETCH,  O_FETCHW);
    add(0, 6'h23, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h23, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h23, 6'h00, 0, 1, ST_MEMADR, O_MEMADR);
    add(0, 6'h23, 6'h00, 0, 1, ST_MEMRD,  O_MEMRD);
    add(0, 6'h23, 6'h00, 0, 1, ST_MEMWB,  O_MEMWB);
    // R-type slt
    add(0, 6'h00, 6'h2a, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h00, 6'h2a, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h00, 6'h2a, 0, 1, ST_EXE,    exe_out(3'b111));
    add(0, 6'h00, 6'h2a, 0, 1, ST_ALUWB,  alwb_out(3'b111));
    // beq taken, then not taken
    add(0, 6'h04, 6'h00, 1, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h04, 6'h00, 1, 1, ST_DECODE, O_DECODE);
    add(0, 6'h04, 6'h00, 1, 1, ST_BRANCH, O_BR_T);
    add(0, 6'h04, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h04, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h04, 6'h00, 0, 1, ST_BRANCH, O_BR_N);
    // sw with three wait cycles in MEMWR
    add(0, 6'h2b, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h2b, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h2b, 6'h00, 0, 1, ST_MEMADR, O_MEMADR);
    add(0, 6'h2b, 6'h00, 0, 0, ST_MEMWR,  O_MEMWR);
    add(0, 6'h2b, 6'h00, 0, 0, ST_MEMWR,  O_MEMWR);
    add(0, 6'h2b, 6'h00, 0, 0, ST_MEMWR,  O_MEMWR);
    add(0, 6'h2b, 6'h00, 0, 1, ST_MEMWR,  O_MEMWR);
    // fetch wait, then illegal opcode
    add(0, 6'h3f, 6'h00, 0, 0, ST_FETCH,  O_FETCHW);
    add(0, 6'h3f, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h3f, 6'h00, 0, 1, ST_DECODE, O_ILL);
    // addi
    add(0, 6'h08, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h08, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h08, 6'h00, 0, 1, ST_ADDIEX, O_MEMADR);
    add(0, 6'h08, 6'h00, 0, 1, ST_ADDIWB, O_ADDIWB);
    // j
    add(0, 6'h02, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h02, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h02, 6'h00, 0, 1, ST_JUMP,   O_JUMP);
    // lw abandoned by reset during MEMRD
    add(0, 6'h23, 6'h00, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h23, 6'h00, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h23, 6'h00, 0, 1, ST_MEMADR, O_MEMADR);
    add(0, 6'h23, 6'h00, 0, 0, ST_MEMRD,  O_MEMRD);
    add(1, 6'h23, 6'h00, 0, 0, ST_MEMRD,  O_MEMRD);
    add(1, 6'h00, 6'h22, 0, 1, ST_FETCH,  O_FETCHW);
    // R-type sub, and, or, unknown funct
    add(0, 6'h00, 6'h22, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h00, 6'h22, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h00, 6'h22, 0, 1, ST_EXE,    exe_out(3'b110));
    add(0, 6'h00, 6'h22, 0, 1, ST_ALUWB,  alwb_out(3'b110));
    add(0, 6'h00, 6'h24, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h00, 6'h24, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h00, 6'h24, 0, 1, ST_EXE,    exe_out(3'b000));
    add(0, 6'h00, 6'h24, 0, 1, ST_ALUWB,  alwb_out(3'b000));
    add(0, 6'h00, 6'h25, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h00, 6'h25, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h00, 6'h25, 0, 1, ST_EXE,    exe_out(3'b001));
    add(0, 6'h00, 6'h25, 0, 1, ST_ALUWB,  alwb_out(3'b001));
    add(0, 6'h00, 6'h3f, 0, 1, ST_FETCH,  O_FETCH);
    add(0, 6'h00, 6'h3f, 0, 1, ST_DECODE, O_DECODE);
    add(0, 6'h00, 6'h3f, 0, 1, ST_EXE,    exe_out(3'b010));
    add(0, 6'h00, 6'h3f, 0, 1, ST_ALUWB,  alwb_out(3'b010));
    add(0, 6'h05, 6'h00, 0, 1, ST_FETCH,  O_FETCH);

    drive(1, 6'h23, 6'h00, 0, 1);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
      #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
    end

    // op 000101 from DECODE: bne when enabled, otherwise illegal
    @(negedge clk);
    drive(0, 6'h05, 6'h00, 0, 1);
    #1;
`ifdef MC_BNE_EN
    check("bne_decode", ST_DECODE, O_DECODE);
    @(negedge clk);
    #1;
    check("bne_nz", ST_BNE, O_BR_T);
    @(negedge clk);
    #1;
    check("bne_ret", ST_FETCH, O_FETCH);
`else
    check("op05_illegal", ST_DECODE, O_ILL);
    @(negedge clk);
    #1;
    check("op05_ret", ST_FETCH, O_FETCH);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control FSM for the multicycle MIPS datapath, which uses a single shared memory and a single ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives the mux selects and write enables of the multicycle datapath. Includes the ALU decoder.
- Stalls on a memory-ready handshake so it can sit in front of slow memory.

Parameters:
- STATE_W, 4: width of the state register. Must be 4 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- memready  in  1  memory has completed the current access this cycle
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- regdst  out  1  write register select: 1 = rd
- memtoreg  out  1  write data select: 1 = Data register
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- illegal  out  1  one-cycle pulse on an undecoded opcode
- state_dbg  out  STATE_W  current state, for debug

Behaviour:
- The state register updates on the rising edge of clk. reset → FETCH. A synchronous reset mid-instruction abandons that instruction.
- While reset = 1, every write enable (pcen, memwrite, irwrite, regwrite) is 0, and illegal = 0.
- Outputs are combinational from the state register (Moore). The only exceptions:
  - memready gates irwrite and pcen in FETCH.
  - zero gates pcen in BRANCH.
- Any output not listed for a state is 0.
- alucontrol comes from aluop:
  - aluop 00 → 010 (add); 01 → 110 (sub).
  - aluop 10 decodes funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct → 010 and still writes back.
- States, outputs and transitions:
  - FETCH: iord = 0, alusrcb = 01, aluop = 00, pcsrc = 00, irwrite = pcen = memready. Stays in FETCH until memready = 1, then → DECODE.
  - DECODE: alusrcb = 11, aluop = 00 (computes the branch target). Next state by op:
    - 100011 / 101011 → MEMADR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - otherwise: illegal = 1 and → FETCH.
  - MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. lw → MEMRD; sw → MEMWR.
  - MEMRD: iord = 1. Holds until memready = 1, then → MEMWB.
  - MEMWB: regdst = 0, memtoreg = 1, regwrite = 1. → FETCH.
  - MEMWR: iord = 1, memwrite = 1 (asserted every cycle while waiting). Holds until memready = 1, then → FETCH.
  - EXECUTE: alusrca = 1, alusrcb = 00, aluop = 10. → ALUWB.
  - ALUWB: regdst = 1, memtoreg = 0, regwrite = 1, alucontrol held at the funct decode. → FETCH.
  - BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, pcen = zero. → FETCH.
  - ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. → ADDIWB.
  - ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1. → FETCH.
  - JUMP: pcsrc = 10, pcen = 1. → FETCH.
- Instruction latency with memready tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each wait cycle (memready = 0) adds exactly one cycle in FETCH, MEMRD or MEMWR.
- Unused state encodings → FETCH on the next edge, with all enables 0.

Optional Feature:
- Macro: MC_BNE_EN.
- When defined:
  - op 000101 in DECODE → BNE state.
  - BNE drives the same outputs as BRANCH, except pcen = ~zero.
  - BNE → FETCH.
- When undefined: op 000101 is illegal (illegal pulse, → FETCH).

Decomposition:
- Shared package mc_pkg holds:
  - the state enum typedef
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE)
  - funct constants
  - ALUCTL_* constants
  - the aluop typedef
- One sub-module, mc_aludec (aluop, funct → alucontrol), instantiated inside mc_controller.

Test Plan:
- Reset, then lw (op = 100011) with memready = 1:
  - state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - regwrite = 1, memtoreg = 1 only in MEMWB.
  - irwrite = pcen = 1 only in FETCH.
- R-type funct 101010 → alucontrol = 111 in EXECUTE and ALUWB; regdst = 1, regwrite = 1 in ALUWB.
- beq twice:
  - zero = 1 → pcen = 1, pcsrc = 01 in BRANCH.
  - zero = 0 → pcen = 0. Both return to FETCH after 3 cycles.
- sw with memready low for 3 cycles in MEMWR:
  - memwrite = 1 for 4 consecutive cycles.
  - → FETCH only after memready = 1.
  - FETCH with memready = 0 keeps irwrite = 0.
- op = 111111: illegal = 1 for exactly one cycle in DECODE, then FETCH. Repeat with op = 000101 and MC_BNE_EN undefined → illegal.
- Reset asserted during MEMRD:
  - next cycle state = FETCH, all enables 0 while reset is high.
  - With MC_BNE_EN defined, bne with zero = 0 → pcen = 1.
